// File: rtl/ripple_count_monitor_if.sv
// Event port bundle for ripple_count_monitor: single-entry valid/ready channel
// carrying the running total and the {skip, ovf, match} flags of an event.
interface ripple_count_monitor_if #(
    parameter int unsigned TOT_W = 12
) ();
    logic             evt_valid;
    logic             evt_ready;
    logic [TOT_W-1:0] evt_data;
    logic [2:0]       evt_kind;

    // Producer side (the monitor)
    modport master (
        output evt_valid,
        output evt_data,
        output evt_kind,
        input  evt_ready
    );

    // Consumer side (control/status logic)
    modport slave (
        input  evt_valid,
        input  evt_data,
        input  evt_kind,
        output evt_ready
    );
endinterface

// File: rtl/ripple_count_monitor.sv
// Observer for a free-running CNT_W-bit counter. Classifies every transition
// as hold/step/skip, extends the count with a wrap counter into a wide total,
// compares that total against a programmable value and reports match,
// overflow and skip events through a single-entry valid/ready port.
module ripple_count_monitor #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned EXT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [CNT_W-1:0]         cnt_in,
    input  logic [CNT_W+EXT_W-1:0]   cmp_val,
    input  logic                     cmp_load,
    input  logic                     clr_err,
    ripple_count_monitor_if.master   evt,
    output logic [CNT_W+EXT_W-1:0]   ext_count,
    output logic                     err_skip,
    output logic                     evt_lost
);
    localparam int unsigned TOT_W = CNT_W + EXT_W;

    typedef enum logic {
        ST_UNPRIMED,
        ST_PRIMED
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   prev_q, prev_d;
    logic [EXT_W-1:0]   wrap_q, wrap_d;
    logic               cmp_en_q, cmp_en_d;
    logic [TOT_W-1:0]   cmp_reg_q, cmp_reg_d;
    logic               evt_valid_q, evt_valid_d;
    logic [TOT_W-1:0]   evt_data_q, evt_data_d;
    logic [2:0]         evt_kind_q, evt_kind_d;
    logic               err_skip_q, err_skip_d;
    logic               evt_lost_q, evt_lost_d;

    logic [CNT_W-1:0]   diff;
    logic               flag_skip;
    logic               flag_ovf;
    logic               flag_match;
    logic               evt_new;
    logic [TOT_W-1:0]   total_next;

    // Classification, compare, event-port and sticky-flag next-state logic
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        wrap_d      = wrap_q;
        cmp_en_d    = cmp_en_q;
        cmp_reg_d   = cmp_reg_q;
        evt_valid_d = evt_valid_q;
        evt_data_d  = evt_data_q;
        evt_kind_d  = evt_kind_q;
        err_skip_d  = err_skip_q;
        evt_lost_d  = evt_lost_q;
        flag_skip   = 1'b0;
        flag_ovf    = 1'b0;
        flag_match  = 1'b0;
        diff        = cnt_in - prev_q;

        case (state_q)
            ST_UNPRIMED: begin
                prev_d  = cnt_in;
                state_d = ST_PRIMED;
            end
            ST_PRIMED: begin
                if (diff == '0) begin
                    // hold: nothing changes
                end else if (diff == CNT_W'(1)) begin
                    prev_d = cnt_in;
                    if (prev_q == '1) begin
                        wrap_d   = wrap_q + EXT_W'(1);
                        flag_ovf = (wrap_q == '1);
                    end
                    flag_match = cmp_en_q && ({wrap_d, cnt_in} == cmp_reg_q);
                end else begin
                    prev_d    = cnt_in;
                    wrap_d    = '0;
                    flag_skip = 1'b1;
                end
            end
            default: state_d = ST_UNPRIMED;
        endcase

        // compare register loads after this edge's compare has used the old value
        if (cmp_load) begin
            cmp_reg_d = cmp_val;
            cmp_en_d  = 1'b1;
        end

        evt_new    = flag_skip || flag_ovf || flag_match;
        total_next = {wrap_d, prev_d};

        if (evt_valid_q && evt.evt_ready) begin
            evt_valid_d = 1'b0;
        end

        // a slot freed on this edge accepts a new event with no bubble
        if (evt_new) begin
            if (!evt_valid_q || evt.evt_ready) begin
                evt_valid_d = 1'b1;
                evt_data_d  = total_next;
                evt_kind_d  = {flag_skip, flag_ovf, flag_match};
            end else begin
                evt_lost_d = 1'b1;
            end
        end

        if (clr_err) begin
            err_skip_d = 1'b0;
            if (!(evt_new && evt_valid_q && !evt.evt_ready)) begin
                evt_lost_d = 1'b0;
            end
        end
        if (flag_skip) begin
            err_skip_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_UNPRIMED;
            prev_q      <= '0;
            wrap_q      <= '0;
            cmp_en_q    <= 1'b0;
            cmp_reg_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_data_q  <= '0;
            evt_kind_q  <= '0;
            err_skip_q  <= 1'b0;
            evt_lost_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            wrap_q      <= wrap_d;
            cmp_en_q    <= cmp_en_d;
            cmp_reg_q   <= cmp_reg_d;
            evt_valid_q <= evt_valid_d;
            evt_data_q  <= evt_data_d;
            evt_kind_q  <= evt_kind_d;
            err_skip_q  <= err_skip_d;
            evt_lost_q  <= evt_lost_d;
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_data  = evt_data_q;
    assign evt.evt_kind  = evt_kind_q;
    assign ext_count     = {wrap_q, prev_q};
    assign err_skip      = err_skip_q;
    assign evt_lost      = evt_lost_q;
endmodule
